// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature decoder with per-channel glitch filter,
// position counter, direction and sticky error flag, and a shared
// velocity window.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   enable        - global count / window enable
//   clr_pos       - per-channel position clear
//   err_clr       - clears all err_flag bits
//   enc_a, enc_b  - raw asynchronous encoder inputs
//   position      - per-channel position, ch i at [i*POS_W +: POS_W]
//   velocity      - counts per window, same packing as position
//   vel_valid     - one-cycle pulse on velocity update
//   direction     - 1 = last counted step was forward
//   err_flag      - sticky illegal-transition flag
// Optional (macro ENC_INDEX_EN):
//   enc_z         - raw index inputs (synchronised, unfiltered)
//   index_clr_en  - clear position on index rising edge
//   index_pos     - position captured at index rising edge
module quad_encoder_array #(
  parameter int NUM_CH        = 4,
  parameter int POS_W         = 32,
  parameter int FILT_CYCLES   = 3,
  parameter int WINDOW_CYCLES = 100000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       clr_pos,
  input  logic                    err_clr,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
`ifdef ENC_INDEX_EN
  input  logic [NUM_CH-1:0]       enc_z,
  input  logic [NUM_CH-1:0]       index_clr_en,
  output logic [NUM_CH*POS_W-1:0] index_pos,
`endif
  output logic [NUM_CH*POS_W-1:0] position,
  output logic [NUM_CH*POS_W-1:0] velocity,
  output logic                    vel_valid,
  output logic [NUM_CH-1:0]       direction,
  output logic [NUM_CH-1:0]       err_flag
);

  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

  logic [WW-1:0] win_cnt;
  logic          win_end;

  // Window counter is frozen while disabled, so the terminal
  // count can only be reached on an enabled cycle.
  assign win_end = enable && (win_cnt == WIN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt   <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= win_end;
      if (win_end)
        win_cnt <= '0;
      else if (enable)
        win_cnt <= win_cnt + WW'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       curr;
    logic [1:0]       prev;
    logic             fwd;
    logic             rev;
    logic             ill;
    logic             idx_clr;
    logic             zero_pos;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] snap_q;
    logic [POS_W-1:0] vel_q;
    logic             dir_q;
    logic             err_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= 2'b00;
        sync2 <= 2'b00;
      end else begin
        sync1 <= {enc_a[g], enc_b[g]};
        sync2 <= sync1;
      end
    end

    if (FILT_CYCLES == 0) begin : g_nofilt
      assign curr = sync2;
    end else begin : g_filt
      localparam int CW =
        (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES + 1) : 1;
      localparam logic [CW-1:0] FC = CW'(FILT_CYCLES);

      logic [1:0]    filt_q;
      logic [1:0]    cand_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_n;
      logic          accept;

      // A candidate that differs from last cycle's sample restarts
      // the stability count at one.
      always_comb begin
        cnt_n  = (sync2 == cand_q) ? cnt_q + CW'(1) : CW'(1);
        accept = (sync2 != filt_q) && (cnt_n >= FC);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          filt_q <= 2'b00;
          cand_q <= 2'b00;
          cnt_q  <= '0;
        end else begin
          cand_q <= sync2;
          if (sync2 == filt_q) begin
            cnt_q <= '0;
          end else if (accept) begin
            filt_q <= sync2;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_n;
          end
        end
      end

      assign curr = filt_q;
    end

    always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      case ({prev, curr})
        4'b0001, 4'b0111,
        4'b1110, 4'b1000: fwd = 1'b1;
        4'b0010, 4'b1011,
        4'b1101, 4'b0100: rev = 1'b1;
        default: ;
      endcase
    end

    assign ill = ((prev ^ curr) == 2'b11);

`ifdef ENC_INDEX_EN
    logic             z_s1;
    logic             z_s2;
    logic             z_q;
    logic             z_rise;
    logic [POS_W-1:0] idx_q;

    assign z_rise  = z_s2 & ~z_q;
    assign idx_clr = z_rise & index_clr_en[g];

    always_ff @(posedge clk) begin
      if (reset) begin
        z_s1  <= 1'b0;
        z_s2  <= 1'b0;
        z_q   <= 1'b0;
        idx_q <= '0;
      end else begin
        z_s1 <= enc_z[g];
        z_s2 <= z_s1;
        z_q  <= z_s2;
        if (z_rise)
          idx_q <= pos_q;
      end
    end

    assign index_pos[g*POS_W +: POS_W] = idx_q;
`else
    assign idx_clr = 1'b0;
`endif

    assign zero_pos = clr_pos[g] | idx_clr;

    // prev tracks curr even while disabled so that re-enabling
    // never decodes a stale transition.
    always_ff @(posedge clk) begin
      if (reset) begin
        prev   <= 2'b00;
        pos_q  <= '0;
        snap_q <= '0;
        vel_q  <= '0;
        dir_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        prev <= curr;

        if (zero_pos)
          pos_q <= '0;
        else if (enable && fwd)
          pos_q <= pos_q + POS_W'(1);
        else if (enable && rev)
          pos_q <= pos_q - POS_W'(1);

        if (win_end)
          vel_q <= pos_q - snap_q;

        if (zero_pos)
          snap_q <= '0;
        else if (win_end)
          snap_q <= pos_q;

        if (clr_pos[g])
          dir_q <= 1'b0;
        else if (enable && fwd)
          dir_q <= 1'b1;
        else if (enable && rev)
          dir_q <= 1'b0;

        if (ill)
          err_q <= 1'b1;
        else if (err_clr)
          err_q <= 1'b0;
      end
    end

    assign position[g*POS_W +: POS_W] = pos_q;
    assign velocity[g*POS_W +: POS_W] = vel_q;
    assign direction[g]               = dir_q;
    assign err_flag[g]                = err_q;
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed self-checking bench for quad_encoder_array.
// Main DUT: 2 ch, 16-bit, filter 2, window 100; aux DUT: 8-bit, no filter.
module tb_quad_encoder_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        err_clr;
  logic [1:0]  clr_pos;
  logic [1:0]  enc_a;
  logic [1:0]  enc_b;
  logic [31:0] position;
  logic [31:0] velocity;
  logic        vel_valid;
  logic [1:0]  direction;
  logic [1:0]  err_flag;

  logic        w_clr;
  logic        w_a;
  logic        w_b;
  logic [7:0]  w_pos;
  logic [7:0]  w_vel;
  logic        w_valid;
  logic        w_dir;
  logic        w_err;

`ifdef ENC_INDEX_EN
  logic [1:0]  enc_z;
  logic [1:0]  index_clr_en;
  logic [31:0] index_pos;
  logic        w_z;
  logic        w_zc;
  logic [7:0]  w_ip;
`endif

  int checks = 0;
  int errors = 0;
  int vv_cnt = 0;
  int k;
  int vv0;

  logic [1:0] fseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 clk = ~clk;

  always @(negedge clk) if (vel_valid === 1'b1) vv_cnt++;

  quad_encoder_array #(
    .NUM_CH(2), .POS_W(16), .FILT_CYCLES(2), .WINDOW_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .clr_pos(clr_pos), .err_clr(err_clr),
    .enc_a(enc_a), .enc_b(enc_b),
`ifdef ENC_INDEX_EN
    .enc_z(enc_z), .index_clr_en(index_clr_en),
    .index_pos(index_pos),
`endif
    .position(position), .velocity(velocity),
    .vel_valid(vel_valid), .direction(direction),
    .err_flag(err_flag)
  );

  quad_encoder_array #(
    .NUM_CH(1), .POS_W(8), .FILT_CYCLES(0), .WINDOW_CYCLES(2)
  ) dut_w8 (
    .clk(clk), .reset(reset), .enable(enable),
    .clr_pos(w_clr), .err_clr(err_clr),
    .enc_a(w_a), .enc_b(w_b),
`ifdef ENC_INDEX_EN
    .enc_z(w_z), .index_clr_en(w_zc),
    .index_pos(w_ip),
`endif
    .position(w_pos), .velocity(w_vel),
    .vel_valid(w_valid), .direction(w_dir),
    .err_flag(w_err)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int ch, input logic [1:0] ab,
                     input int n);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
    tick(n);
  endtask

  function automatic logic [15:0] pos(input int ch);
    return position[ch*16 +: 16];
  endfunction

  function automatic logic [15:0] vel(input int ch);
    return velocity[ch*16 +: 16];
  endfunction

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    err_clr = 1'b0;
    clr_pos = 2'b00;
    enc_a   = 2'b00;
    enc_b   = 2'b00;
    w_clr   = 1'b0;
    w_a     = 1'b0;
    w_b     = 1'b0;
`ifdef ENC_INDEX_EN
    enc_z        = 2'b00;
    index_clr_en = 2'b00;
    w_z          = 1'b0;
    w_zc         = 1'b0;
`endif
    tick(3);
    chk("rst_position", position, 32'h0);
    chk("rst_velocity", velocity, 32'h0);
    chk("rst_vel_valid", vel_valid, 1'b0);
    chk("rst_direction", direction, 2'b00);
    chk("rst_err_flag", err_flag, 2'b00);
`ifdef ENC_INDEX_EN
    chk("rst_index_pos", index_pos, 32'h0);
`endif
    reset  = 1'b0;
    enable = 1'b1;

    // ch0 forward: latency then 8 steps total
    drv(0, 2'b01, 4);
    chk("lat_4cyc", pos(0), 16'd0);
    tick(1);
    chk("lat_5cyc", pos(0), 16'd1);
    tick(5);
    for (int s = 1; s < 8; s++) drv(0, fseq[(s+1)%4], 10);
    chk("fwd8_pos0", pos(0), 16'd8);
    chk("fwd8_dir0", direction[0], 1'b1);
    chk("fwd8_pos1", pos(1), 16'd0);

    // ch1 reverse 3 steps, then glitches
    drv(1, 2'b10, 10);
    drv(1, 2'b11, 10);
    drv(1, 2'b01, 10);
    chk("rev3_pos1", pos(1), 16'hFFFD);
    chk("rev3_dir1", direction[1], 1'b0);
    enc_a[1] = 1'b1;
    tick(1);
    enc_a[1] = 1'b0;
    tick(10);
    chk("glitch_a_pos1", pos(1), 16'hFFFD);
    enc_b[1] = 1'b0;
    tick(1);
    enc_b[1] = 1'b1;
    tick(10);
    chk("glitch_b_pos1", pos(1), 16'hFFFD);
    chk("glitch_err1", err_flag[1], 1'b0);

    // illegal transition and err_clr
    drv(0, 2'b11, 10);
    chk("ill_err0", err_flag[0], 1'b1);
    chk("ill_pos0", pos(0), 16'd8);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("errclr_err0", err_flag[0], 1'b0);
    drv(0, 2'b00, 4);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ill_vs_clr_err0", err_flag[0], 1'b1);
    chk("ill2_pos0", pos(0), 16'd8);
    tick(5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // velocity window from a fresh reset
    enc_b[1] = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(2);
    chk("rst2_position", position, 32'h0);
    reset = 1'b0;
    k = 0;
    for (int s = 0; s < 20; s++) begin
      drv(0, fseq[(s+1)%4], 4);
      k += 4;
    end
    while (vel_valid !== 1'b1 && k < 150) begin
      tick(1);
      k++;
    end
    chk("win1_cycle", k, 100);
    chk("win1_vel0", vel(0), 16'd20);
    chk("win1_vel1", vel(1), 16'd0);
    chk("win1_pos0", pos(0), 16'd20);
    tick(1);
    k++;
    chk("win1_pulse_end", vel_valid, 1'b0);
    while (vel_valid !== 1'b1 && k < 250) begin
      tick(1);
      k++;
    end
    chk("win2_cycle", k, 200);
    chk("win2_vel0", vel(0), 16'd0);

    // 8-bit aux: latency without filter, then wrap 7F->80
    w_a = 1'b0;
    w_b = 1'b1;
    tick(2);
    chk("w8_lat2", w_pos, 8'd0);
    tick(1);
    chk("w8_lat3", w_pos, 8'd1);
    for (int s = 1; s < 127; s++) begin
      {w_a, w_b} = fseq[(s+1)%4];
      tick(2);
    end
    tick(2);
    chk("w8_pos_7f", w_pos, 8'h7F);
    {w_a, w_b} = fseq[0];
    tick(4);
    chk("w8_wrap_80", w_pos, 8'h80);
    chk("w8_dir", w_dir, 1'b1);

    // clear, and clear against a same-cycle step
    clr_pos = 2'b01;
    tick(1);
    clr_pos = 2'b00;
    chk("clr_pos0", pos(0), 16'd0);
    chk("clr_dir0", direction[0], 1'b0);
    drv(0, 2'b01, 4);
    clr_pos = 2'b01;
    tick(1);
    clr_pos = 2'b00;
    chk("clr_vs_step", pos(0), 16'd0);
    tick(5);
    chk("clr_vs_step_late", pos(0), 16'd0);
    drv(0, 2'b00, 10);
    chk("wrap_under_pos0", pos(0), 16'hFFFF);
    chk("wrap_under_dir0", direction[0], 1'b0);

    // enable low: position and window frozen
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);
    enable = 1'b0;
    vv0 = vv_cnt;
    for (int s = 0; s < 7; s++) drv(0, fseq[(s+1)%4], 5);
    tick(15);
    chk("dis_pos0", pos(0), 16'd0);
    chk("dis_no_valid", vv_cnt - vv0, 0);
    enable = 1'b1;
    k = 0;
    while (vel_valid !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    chk("reen_win_cycle", k, 70);
    chk("reen_pos0", pos(0), 16'd0);
    chk("reen_vel0", vel(0), 16'd0);

`ifdef ENC_INDEX_EN
    for (int s = 0; s < 42; s++) drv(0, fseq[s%4], 3);
    tick(5);
    chk("idx_pre_pos0", pos(0), 16'd42);
    enc_z[0]        = 1'b1;
    index_clr_en[0] = 1'b1;
    tick(3);
    chk("idx_pos0", index_pos[15:0], 16'd42);
    chk("idx_clr_pos0", pos(0), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
